// File: rtl/fp_to_linear_decoder.sv
// Expands an 8-bit float code {S, E[2:0], F[3:0]} into a 12-bit two's-complement
// linear sample, shifting the significand one bit per clock.
module fp_to_linear_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  fp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] lin_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] SIGN  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [10:0] mag;
    logic [2:0]  cnt;
    logic        sign;
    logic [11:0] result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mag    <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag   <= {7'b0, fp_in[3:0]};
                        cnt   <= fp_in[6:4];
                        sign  <= fp_in[7];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != 3'd0) begin
                        mag <= {mag[9:0], 1'b0};
                        cnt <= cnt - 3'd1;
                    end else begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    // Negating a zero magnitude wraps back to zero, so -0 decodes as 0.
                    result <= sign ? (~{1'b0, mag} + 12'd1) : {1'b0, mag};
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign lin_out   = result;

endmodule

// File: tb/tb_fp_to_linear_decoder.sv
// Scoreboard bench for fp_to_linear_decoder: expected values are queued on
// accept and compared when the decoder presents a result.
module tb_fp_to_linear_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  fp_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] lin_out;

    int vectors = 0;
    int miscompares = 0;
    logic [11:0] exp_q[$];

    fp_to_linear_decoder dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fp_in(fp_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lin_out(lin_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] model(input logic [7:0] code);
        int v;
        v = int'(code[3:0]) * (1 << int'(code[6:4]));
        if (code[7]) v = -v;
        return v[11:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || lin_out !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b lin_out=%h, required 1 0 000",
                     in_ready, out_valid, lin_out);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || lin_out !== 12'h000) begin
            miscompares++;
            $display("FAIL after_release: in_ready=%b out_valid=%b lin_out=%h, required 1 0 000",
                     in_ready, out_valid, lin_out);
        end
    endtask

    task automatic test_decode(input logic [7:0] code, input logic [11:0] expv);
        int n;
        logic [11:0] want;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL decode_%h_ready: in_ready=%b, required 1", code, in_ready);
        end
        in_valid = 1'b1;
        fp_in = code;
        exp_q.push_back(expv);
        tick();
        in_valid = 1'b0;
        fp_in = '0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n != int'(code[6:4]) + 2) begin
            miscompares++;
            $display("FAIL decode_%h_latency: %0d edges, required %0d", code, n, int'(code[6:4]) + 2);
        end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        vectors++;
        if (lin_out !== want) begin
            miscompares++;
            $display("FAIL decode_%h_value: lin_out=%h, required %h", code, lin_out, want);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || lin_out !== want) begin
            miscompares++;
            $display("FAIL decode_%h_handshake: out_valid=%b in_ready=%b lin_out=%h, required 0 1 %h",
                     code, out_valid, in_ready, lin_out, want);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int seen;
        in_valid = 1'b1;
        fp_in = 8'h25;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL bp_latency: %0d edges, required 4", n);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            fp_in = 8'h11;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || lin_out !== 12'h014 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: out_valid=%b lin_out=%h in_ready=%b, required 1 014 0",
                         i, out_valid, lin_out, in_ready);
            end
        end
        in_valid = 1'b0;
        fp_in = '0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL bp_not_consumed: out_valid seen %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        in_valid = 1'b1;
        fp_in = 8'h70;
        tick();
        in_valid = 1'b0;
        fp_in = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || lin_out !== 12'h000 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_outputs: out_valid=%b lin_out=%h in_ready=%b, required 0 000 1",
                     out_valid, lin_out, in_ready);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midreset_discard: out_valid seen %0d cycles, required 0", seen);
        end
        test_decode(8'h21, 12'h004);
    endtask

    task automatic test_back_to_back();
        int idx;
        int cyc;
        int last_acc;
        int last_e;
        int done_cnt;
        logic [11:0] want;
        idx = 0;
        cyc = 0;
        last_acc = -1;
        last_e = 0;
        done_cnt = 0;
        out_ready = 1'b1;
        while (done_cnt < 256 && cyc < 5000) begin
            if (idx < 256) begin
                in_valid = 1'b1;
                fp_in = idx[7:0];
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc != last_e + 4) begin
                        miscompares++;
                        $display("FAIL b2b_interval_%0d: %0d cycles, required %0d",
                                 idx, cyc - last_acc, last_e + 4);
                    end
                end
                last_acc = cyc;
                last_e = (idx >> 4) & 7;
                exp_q.push_back(model(idx[7:0]));
                idx++;
            end
            if (out_valid === 1'b1) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
                vectors++;
                if (lin_out !== want) begin
                    miscompares++;
                    $display("FAIL b2b_value_%0d: lin_out=%h, required %h", done_cnt, lin_out, want);
                end
                done_cnt++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (done_cnt != 256 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: %0d results with %0d pending, required 256 and 0",
                     done_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_decode(8'h00, 12'h000);
        test_decode(8'h7F, 12'h780);
        test_decode(8'hB5, 12'hFD8);
        test_decode(8'h80, 12'h000);
        test_decode(8'h9F, 12'hFE2);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
